// File: rtl/i2c_pkg.sv
// Shared constants for the I2C target: FSM state encodings, ACK/NACK levels, default address.
package i2c_pkg;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StAddr    = 4'd1;
  localparam logic [3:0] StAddrAck = 4'd2;
  localparam logic [3:0] StWrData  = 4'd3;
  localparam logic [3:0] StWrAck   = 4'd4;
  localparam logic [3:0] StRdData  = 4'd5;
  localparam logic [3:0] StRdAck   = 4'd6;
  localparam logic [3:0] StIgnore  = 4'd7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h3C;

endpackage

// File: rtl/i2c_oled_slave_if.sv
// Pin-level and user-side signals of the I2C target, with target (slave) and bench/master views.
interface i2c_oled_slave_if;

  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic       sda_t;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [4:0] byte_cnt;
  logic       busy;
  logic       start_det;
  logic       stop_det;
  logic       nack_det;
  logic [3:0] state_i2c;

  modport slave (
    input  scl_i, sda_i, tx_data,
    output sda_o, sda_t, rx_data, rx_valid, tx_req, byte_cnt, busy,
           start_det, stop_det, nack_det, state_i2c
  );

  modport master (
    output scl_i, sda_i, tx_data,
    input  sda_o, sda_t, rx_data, rx_valid, tx_req, byte_cnt, busy,
           start_det, stop_det, nack_det, state_i2c
  );

endinterface

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer and START/STOP/edge detector; the glitch filter is present only when
// I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_line_sync #(
  parameter int unsigned FILT_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  if (FILT_CYC == 0) begin : g_bad_filt_cyc
    $error("FILT_CYC must be at least 1");
  end

  // Bit 1 carries SCL, bit 0 carries SDA; idle bus is high.
  logic [1:0] meta_q, sync_q, prev_q, line;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
    end else begin
      meta_q <= {scl_i, sda_i};
      sync_q <= meta_q;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int unsigned CntW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

  logic [1:0]      filt_q;
  logic [CntW-1:0] cnt_q [2];

  // A line only follows its synced input after FILT_CYC consecutive differing samples.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        filt_q[i] <= 1'b1;
        cnt_q[i]  <= '0;
      end else if (sync_q[i] == filt_q[i]) begin
        cnt_q[i] <= '0;
      end else if (cnt_q[i] == CntW'(FILT_CYC - 1)) begin
        filt_q[i] <= sync_q[i];
        cnt_q[i]  <= '0;
      end else begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign line = filt_q;
`else
  assign line = sync_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= 2'b11;
    end else begin
      prev_q <= line;
    end
  end

  assign sda_s_o     = line[0];
  assign scl_rise_o  = line[1] & ~prev_q[1];
  assign scl_fall_o  = ~line[1] & prev_q[1];
  assign start_det_o = line[1] & prev_q[1] & prev_q[0] & ~line[0];
  assign stop_det_o  = line[1] & prev_q[1] & ~prev_q[0] & line[0];

endmodule

// File: rtl/i2c_oled_slave.sv
// I2C target: address match/ACK, byte write strobes and byte read requests, no clock stretching.
// Optional glitch filter on SCL/SDA via I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_oled_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLV_ADDR = I2C_DEFAULT_ADDR,
  parameter int unsigned FILT_CYC = 4
) (
  input logic                clk,
  input logic                rst,
  i2c_oled_slave_if.slave    bus_io
);

  logic sda_s, scl_rise, scl_fall, start_ev, stop_ev;

  i2c_line_sync #(
    .FILT_CYC (FILT_CYC)
  ) u_line_sync (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (bus_io.scl_i),
    .sda_i       (bus_io.sda_i),
    .sda_s_o     (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_ev),
    .stop_det_o  (stop_ev)
  );

  logic [3:0] state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [4:0] byte_cnt_q, byte_cnt_d;
  logic       rw_q, rw_d;
  logic       sda_t_q, sda_t_d;
  logic       busy_q, busy_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       nack_q, nack_d;

  logic [4:0] byte_cnt_inc;
  assign byte_cnt_inc = (byte_cnt_q == 5'd31) ? byte_cnt_q : byte_cnt_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    byte_cnt_d = byte_cnt_q;
    rw_d       = rw_q;
    sda_t_d    = sda_t_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    nack_d     = 1'b0;

    if (start_ev) begin
      state_d    = StAddr;
      bit_cnt_d  = 4'd0;
      byte_cnt_d = 5'd0;
      sda_t_d    = 1'b1;
      busy_d     = 1'b0;
      start_d    = 1'b1;
    end else if (stop_ev) begin
      state_d = StIdle;
      sda_t_d = 1'b1;
      busy_d  = 1'b0;
      stop_d  = 1'b1;
    end else begin
      case (state_q)
        StAddr: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            // Early request gives user logic the whole ACK slot to present tx_data.
            if (bit_cnt_q == 4'd7 && shift_q[6:0] == SLV_ADDR && sda_s) tx_req_d = 1'b1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == SLV_ADDR) begin
              sda_t_d = I2C_ACK;
              busy_d  = 1'b1;
              rw_d    = shift_q[0];
              state_d = StAddrAck;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (!rw_q) begin
              sda_t_d = 1'b1;
              state_d = StWrData;
            end else begin
              shift_d = bus_io.tx_data;
              sda_t_d = bus_io.tx_data[7];
              state_d = StRdData;
            end
          end
        end
        StWrData: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            byte_cnt_d = byte_cnt_inc;
            sda_t_d    = I2C_ACK;
            state_d    = StWrAck;
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            sda_t_d   = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = StWrData;
          end
        end
        StRdData: begin
          // Open-drain: releasing the line sends a 1, pulling low sends a 0.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_t_d    = 1'b1;
              byte_cnt_d = byte_cnt_inc;
              state_d    = StRdAck;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_t_d   = shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              tx_req_d = 1'b1;
            end else begin
              nack_d  = 1'b1;
              sda_t_d = 1'b1;
              state_d = StIgnore;
            end
          end else if (scl_fall) begin
            shift_d   = bus_io.tx_data;
            sda_t_d   = bus_io.tx_data[7];
            bit_cnt_d = 4'd0;
            state_d   = StRdData;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      byte_cnt_q <= 5'd0;
      rw_q       <= 1'b0;
      sda_t_q    <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      byte_cnt_q <= byte_cnt_d;
      rw_q       <= rw_d;
      sda_t_q    <= sda_t_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      nack_q     <= nack_d;
    end
  end

  assign bus_io.sda_o     = 1'b0;
  assign bus_io.sda_t     = sda_t_q;
  assign bus_io.rx_data   = rx_data_q;
  assign bus_io.rx_valid  = rx_valid_q;
  assign bus_io.tx_req    = tx_req_q;
  assign bus_io.byte_cnt  = byte_cnt_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.start_det = start_q;
  assign bus_io.stop_det  = stop_q;
  assign bus_io.nack_det  = nack_q;
  assign bus_io.state_i2c = state_q;

endmodule
